press_classifier: RTL and testbench
===================================

# press_classifier

Classifies debounced push-button activity into short, long and double presses. Sits directly downstream of the debouncer and consumes its single-cycle `rise`/`fall` edge pulses. Emits one-cycle event pulses and a wrapping event count for the control logic above it. All timing is in `clock` cycles, with small parameter defaults so short simulations stay practical.

## Interface
Parameters:
- `LONG_COUNT`, default 8: cycles a press must be held after `rise` to be classified long. Legal range ≥ 2.
- `GAP_COUNT`, default 6: maximum cycles after the first release in which a second `rise` makes a double press. Legal range ≥ 2.

Ports:
- `clock` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `rise` in 1: one-cycle pulse when the debounced button goes 0→1.
- `fall` in 1: one-cycle pulse when the debounced button goes 1→0.
- `short_press` out 1: one-cycle pulse.
- `long_press` out 1: one-cycle pulse.
- `double_press` out 1: one-cycle pulse.
- `busy` out 1: high whenever state ≠ IDLE.
- `press_count` out 8: count of classified events, modulo 256.

## Operation
- One internal counter `cnt`, width $clog2(max(LONG_COUNT,GAP_COUNT)+1). It is cleared on every state entry.
- `rise` and `fall` asserted in the same cycle: both are ignored, in every state.
- States and transitions:
  - IDLE
    - `rise` → PRESS1.
    - `fall` is ignored.
  - PRESS1
    - `fall` → GAP. No output.
    - No `fall` and `cnt == LONG_COUNT-1` → HOLD. Pulse `long_press`.
    - Otherwise `cnt++`.
    - `rise` is ignored.
  - HOLD
    - `fall` → IDLE. No output.
    - `rise` is ignored.
  - GAP
    - `rise` → PRESS2.
    - No `rise` and `cnt == GAP_COUNT-1` → IDLE. Pulse `short_press`.
    - Otherwise `cnt++`.
    - `fall` is ignored.
  - PRESS2
    - `fall` → IDLE. Pulse `double_press`.
    - Hold duration is not measured. `rise` is ignored.
- Priority rules:
  - In PRESS1, a `fall` on the threshold edge wins over the long classification, so the press goes to GAP.
  - In GAP, a `rise` on the timeout edge wins over the timeout, so the press goes to PRESS2.
- At most one of the three pulses is high in any cycle.
- `press_count` increments on the same edge that raises any pulse. It wraps 255→0.
- `busy` is decoded directly from the state register.

## Timing
- All outputs are registered or decoded from registers. There are no combinational paths from input to output.
- Reset values: state IDLE, `cnt` 0, all pulses 0, `busy` 0, `press_count` 0.
- Reset asserted in any state:
  - Aborts the operation at the next edge with no pulse emitted.
  - Reset has priority over `rise`/`fall` sampled on the same edge.
- Edge numbering below: the edge sampling `rise` in IDLE is edge R, and the edge sampling the first `fall` is edge F.
- `long_press` is high in the cycle after edge R+LONG_COUNT, provided no `fall` is sampled at edges R+1..R+LONG_COUNT.
- `short_press` is high in the cycle after edge F+GAP_COUNT, provided no `rise` is sampled at edges F+1..F+GAP_COUNT.
- `double_press` is high in the cycle after the edge that samples the second `fall`.
- `busy` rises in the cycle after edge R. It falls in the cycle after the edge that returns the FSM to IDLE.
- Minimum back-to-back operation: a new `rise` sampled in the first IDLE cycle is accepted.

## Test plan
All scenarios use the defaults LONG_COUNT=8 and GAP_COUNT=6.
- Reset held for 3 cycles with random `rise`/`fall`:
  - All outputs stay 0 and `press_count` stays 0.
- Short press: `rise`@edge0, `fall`@3, then idle.
  - `short_press` is high for exactly one cycle after edge 9.
  - `press_count` becomes 1.
  - `busy` is low after edge 9.
- Long press: `rise`@0, `fall`@20.
  - `long_press` pulses after edge 8.
  - No other pulse occurs.
  - `busy` drops after edge 20 and `press_count` becomes 1.
- Double press: `rise`@0, `fall`@2, `rise`@8, `fall`@12.
  - The second `rise` lands exactly on the GAP timeout edge and must win.
  - `double_press` pulses after edge 12. `short_press` never fires.
- Boundary: `rise`@0, `fall`@8 (same edge as the long threshold).
  - No `long_press`.
  - `short_press` pulses after edge 14.
  - Also check that simultaneous `rise`+`fall` in IDLE is ignored: `busy` stays 0.
- Reset mid-operation: `rise`@0, `fall`@2, `reset`@4.
  - No pulse is emitted and the FSM returns to IDLE.
  - A fresh press, `rise`@10 and `fall`@12, gives `short_press` after edge 18 and `press_count`=1.
- Wrap: 256 consecutive short presses.
  - `press_count` returns to 0.

Source files
------------

// File: rtl/press_classifier.sv
// press_classifier: turns debounced rise/fall edge pulses into short, long
// and double press events, plus a wrapping count of classified events.
module press_classifier #(
  parameter int LONG_COUNT = 8,
  parameter int GAP_COUNT  = 6
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       rise,
  input  logic       fall,
  output logic       short_press,
  output logic       long_press,
  output logic       double_press,
  output logic       busy,
  output logic [7:0] press_count
);

  localparam int MAXC = (LONG_COUNT > GAP_COUNT) ? LONG_COUNT : GAP_COUNT;
  localparam int CW   = $clog2(MAXC + 1);
  localparam logic [CW-1:0] LONG_LAST = CW'(LONG_COUNT - 1);
  localparam logic [CW-1:0] GAP_LAST  = CW'(GAP_COUNT - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    PRESS1 = 3'd1,
    HOLD   = 3'd2,
    GAP    = 3'd3,
    PRESS2 = 3'd4
  } state_t;

  state_t          state, state_nxt;
  logic [CW-1:0]   cnt, cnt_nxt;
  logic            short_nxt, long_nxt, double_nxt;
  logic            ev_rise, ev_fall;

  // A simultaneous rise+fall is contradictory, so neither edge is honoured.
  assign ev_rise = rise & ~fall;
  assign ev_fall = fall & ~rise;

  // Next-state, counter and pulse decode; fall/rise beat the timers on their
  // threshold edge because they are tested first.
  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    short_nxt  = 1'b0;
    long_nxt   = 1'b0;
    double_nxt = 1'b0;
    case (state)
      IDLE: begin
        if (ev_rise) state_nxt = PRESS1;
      end
      PRESS1: begin
        if (ev_fall) begin
          state_nxt = GAP;
        end else if (cnt == LONG_LAST) begin
          state_nxt = HOLD;
          long_nxt  = 1'b1;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      HOLD: begin
        if (ev_fall) state_nxt = IDLE;
      end
      GAP: begin
        if (ev_rise) begin
          state_nxt = PRESS2;
        end else if (cnt == GAP_LAST) begin
          state_nxt = IDLE;
          short_nxt = 1'b1;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      PRESS2: begin
        if (ev_fall) begin
          state_nxt  = IDLE;
          double_nxt = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
    // Every state entry starts the timer from zero.
    if (state_nxt != state) cnt_nxt = '0;
  end

  // State, timer, registered event pulses and the event counter.
  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= IDLE;
      cnt          <= '0;
      short_press  <= 1'b0;
      long_press   <= 1'b0;
      double_press <= 1'b0;
      press_count  <= 8'd0;
    end else begin
      state        <= state_nxt;
      cnt          <= cnt_nxt;
      short_press  <= short_nxt;
      long_press   <= long_nxt;
      double_press <= double_nxt;
      if (short_nxt | long_nxt | double_nxt) press_count <= press_count + 8'd1;
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_press_classifier.sv
// tb_press_classifier: directed test-plan scenarios plus random edges, all
// checked against a timestamp-based reference model of the press rules.
module tb_press_classifier;

  localparam int LONG = 8;
  localparam int GAPC = 6;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       rise  = 1'b0;
  logic       fall  = 1'b0;
  logic       short_press, long_press, double_press, busy;
  logic [7:0] press_count;

  int n_cmp = 0;
  int n_err = 0;
  int edge_n = 0;

  // Reference model: remembers edge numbers of the first rise, first fall and
  // second rise of the current operation, and applies the timing rules to
  // the distances between them.
  bit         m_active = 0;
  bit         m_long   = 0;
  int         m_r1 = -1, m_f1 = -1, m_r2 = -1;
  logic [7:0] m_count = 8'd0;
  logic       e_short, e_long, e_double;

  press_classifier #(.LONG_COUNT(LONG), .GAP_COUNT(GAPC)) dut (
    .clock(clock), .reset(reset), .rise(rise), .fall(fall),
    .short_press(short_press), .long_press(long_press),
    .double_press(double_press), .busy(busy), .press_count(press_count)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s edge=%0d observed=%0h expected=%0h", tag, edge_n, obs, exp);
    end
  endtask

  task automatic model_edge(input bit r_in, input bit f_in, input bit rst);
    bit r, f;
    r = r_in && !f_in;
    f = f_in && !r_in;
    e_short = 0; e_long = 0; e_double = 0;
    if (rst) begin
      m_active = 0; m_long = 0; m_r1 = -1; m_f1 = -1; m_r2 = -1; m_count = 8'd0;
    end else if (!m_active) begin
      if (r) begin
        m_active = 1; m_long = 0; m_r1 = edge_n; m_f1 = -1; m_r2 = -1;
      end
    end else if (m_long) begin
      if (f) m_active = 0;
    end else if (m_f1 < 0) begin
      if (f) m_f1 = edge_n;
      else if (edge_n - m_r1 == LONG) begin m_long = 1; e_long = 1; end
    end else if (m_r2 < 0) begin
      if (r) m_r2 = edge_n;
      else if (edge_n - m_f1 == GAPC) begin m_active = 0; e_short = 1; end
    end else begin
      if (f) begin m_active = 0; e_double = 1; end
    end
    if (!rst && (e_short || e_long || e_double)) m_count = m_count + 8'd1;
  endtask

  // One clock: drive on the falling edge, model the rising edge, check 1ns later.
  task automatic step(input bit r, input bit f, input bit rst);
    @(negedge clock);
    rise = r; fall = f; reset = rst;
    @(posedge clock);
    model_edge(r, f, rst);
    #1;
    chk("short_press",  {7'd0, short_press},  {7'd0, e_short});
    chk("long_press",   {7'd0, long_press},   {7'd0, e_long});
    chk("double_press", {7'd0, double_press}, {7'd0, e_double});
    chk("busy",         {7'd0, busy},         {7'd0, m_active});
    chk("press_count",  press_count,          m_count);
    edge_n++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0);
  endtask

  int seen;

  initial begin
    // Reset for 3 cycles with random edges: everything reads zero.
    for (int i = 0; i < 3; i++) step(1'($urandom), 1'($urandom), 1);
    chk("reset_count", press_count, 8'd0);

    // Short press: rise@0 fall@3 -> short after edge 9.
    step(1, 0, 0); idle(2); step(0, 1, 0); idle(5);
    step(0, 0, 0);
    chk("short_edge9", {7'd0, short_press}, 8'd1);
    chk("short_busy", {7'd0, busy}, 8'd0);
    chk("short_cnt", press_count, 8'd1);
    idle(2);

    // Long press: rise@0, fall@20 -> long after edge 8.
    step(0, 0, 1);
    step(1, 0, 0); idle(7);
    step(0, 0, 0);
    chk("long_edge8", {7'd0, long_press}, 8'd1);
    idle(11); step(0, 1, 0);
    chk("long_busy", {7'd0, busy}, 8'd0);
    chk("long_cnt", press_count, 8'd1);
    idle(2);

    // Double press with second rise on the gap-timeout edge.
    step(0, 0, 1);
    step(1, 0, 0); idle(1); step(0, 1, 0); idle(5); step(1, 0, 0);
    chk("dbl_no_short", {7'd0, short_press}, 8'd0);
    idle(3); step(0, 1, 0);
    chk("dbl_edge12", {7'd0, double_press}, 8'd1);
    idle(8);

    // Boundary: fall on long threshold edge -> short after edge 14.
    step(0, 0, 1);
    step(1, 0, 0); idle(7); step(0, 1, 0);
    chk("bnd_no_long", {7'd0, long_press}, 8'd0);
    idle(5); step(0, 0, 0);
    chk("bnd_short14", {7'd0, short_press}, 8'd1);
    // Simultaneous rise+fall in IDLE is ignored.
    step(1, 1, 0);
    chk("both_idle_busy", {7'd0, busy}, 8'd0);
    idle(2);

    // Reset mid-operation, then a fresh press.
    step(0, 0, 1);
    step(1, 0, 0); idle(1); step(0, 1, 0); idle(1); step(0, 0, 1);
    chk("rst_mid_busy", {7'd0, busy}, 8'd0);
    idle(5); step(1, 0, 0); idle(1); step(0, 1, 0); idle(5); step(0, 0, 0);
    chk("rst_fresh_short", {7'd0, short_press}, 8'd1);
    chk("rst_fresh_cnt", press_count, 8'd1);

    // Wrap: 256 back-to-back short presses from a cleared counter.
    step(0, 0, 1);
    for (int p = 0; p < 256; p++) begin
      step(1, 0, 0); step(0, 1, 0); idle(GAPC);
    end
    chk("wrap_cnt", press_count, 8'd0);
    chk("wrap_busy", {7'd0, busy}, 8'd0);

    // Random edges, occasional reset.
    seen = 0;
    for (int i = 0; i < 1500; i++) begin
      int v;
      v = int'($urandom_range(0, 99));
      step(v < 12 || v == 99, v >= 12 && v < 26 || v == 99, v == 98);
      if (short_press || long_press || double_press) seen++;
    end
    chk("rand_any_events", {7'd0, seen > 0}, 8'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
